kp_pixel_source: RTL

//  Responder side of the kernel-control pixel request handshake. Answers the
//  o_req level from kp_kernel_control by pulling pixels from an upstream

---
 rtl/kp_pixel_source.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/kp_pixel_source.sv
// kp_pixel_source
//   Responder side of the kernel-control pixel request handshake. While
//   i_req is high and the block is ACTIVE, pixels are pulled from an upstream
//   FIFO with 1-cycle read latency and presented on o_data/o_valid. Column and
//   row position are tracked per delivered pixel, and frame boundaries are
//   flagged.
//
//   Build option: define KP_PIXEL_SOURCE_TESTPAT_EN to replace FIFO data with a
//   {row[7:0], col[7:0]} test pattern. In that build the FIFO is ignored:
//   o_fifo_rd stays 0, empty is treated as 0 and o_underrun stays 0.
//
// Ports
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_enable       level; low parks the block in IDLE once the frame completes
//   i_req          pixel request level from kp_kernel_control
//   o_data/o_valid pixel and 1-cycle strobe, 1 cycle after the FIFO read
//   o_fifo_rd      upstream FIFO read strobe (combinational)
//   i_fifo_data    upstream FIFO data, valid 1 cycle after o_fifo_rd
//   i_fifo_empty   upstream FIFO empty
//   o_sof/o_eol    start of frame / end of line, qualified by o_valid
//   o_frame_done   1-cycle pulse the cycle after the last pixel of a frame
//   o_underrun     saturating count of ACTIVE cycles with req & empty
module kp_pixel_source #(
    parameter int LINE_LENGTH = 48,
    parameter int LINE_COUNT  = 48,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_req,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_fifo_rd,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_frame_done,
    output logic [15:0]           o_underrun
);

    localparam int CW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int RW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(LINE_LENGTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(LINE_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] col;      // position of the pixel on / next on o_valid
    logic [RW-1:0] row;
    logic [CW-1:0] rd_col;   // position of the next pixel to be read
    logic [RW-1:0] rd_row;
    logic          starved;
    logic          rd;
    logic          rd_last;
    logic          out_last;

`ifdef KP_PIXEL_SOURCE_TESTPAT_EN
    logic [DATA_WIDTH-1:0] tp_data;
    logic [7:0]            tp_row8;
    logic [7:0]            tp_col8;
    logic                  unused_fifo;

    assign starved     = 1'b0;
    assign o_fifo_rd   = 1'b0;
    assign unused_fifo = ^{i_fifo_data, i_fifo_empty};
    assign tp_row8     = 8'(rd_row);
    assign tp_col8     = 8'(rd_col);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tp_data <= '0;
        end else begin
            tp_data <= rd ? DATA_WIDTH'({tp_row8, tp_col8}) : '0;
        end
    end

    assign o_data = tp_data;
`else
    assign starved   = i_fifo_empty;
    assign o_fifo_rd = rd;
    // The FIFO's own output register is the data pipeline stage; gating with
    // o_valid keeps o_data at 0 outside pixel strobes and during reset.
    assign o_data    = o_valid ? i_fifo_data : '0;
`endif

    assign rd       = (state == ST_ACTIVE) & i_req & ~starved;
    assign rd_last  = (rd_col == LAST_COL) & (rd_row == LAST_ROW);
    assign out_last = (col == LAST_COL) & (row == LAST_ROW);

    assign o_sof = o_valid & (col == '0) & (row == '0);
    assign o_eol = o_valid & (col == LAST_COL);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            col          <= '0;
            row          <= '0;
            rd_col       <= '0;
            rd_row       <= '0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_underrun   <= '0;
        end else begin
            o_valid      <= rd;
            o_frame_done <= o_valid & out_last;

            if (o_valid) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            if (rd) begin
                if (rd_col == LAST_COL) begin
                    rd_col <= '0;
                    rd_row <= (rd_row == LAST_ROW) ? '0 : rd_row + RW'(1);
                end else begin
                    rd_col <= rd_col + CW'(1);
                end
            end

            if ((state == ST_ACTIVE) & i_req & starved & ~(&o_underrun)) begin
                o_underrun <= o_underrun + 16'd1;
            end

            // An enable drop in ACTIVE is only acted on via DONE, so a frame
            // in progress always runs to its last pixel.
            case (state)
                ST_IDLE:   if (i_enable) state <= ST_ACTIVE;
                ST_ACTIVE: if (rd & rd_last) state <= ST_DONE;
                ST_DONE:   state <= i_enable ? ST_ACTIVE : ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule
